// File: rtl/fifo_bank_pkg.sv
// Shared defaults and types for the four-lane FIFO bank.
// Optional feature macro: FIFO_BANK_ERROR_EN (sticky per-lane error flags).
package fifo_bank_pkg;

  localparam int DEFAULT_DATA_W       = 8;
  localparam int DEFAULT_DEPTH        = 8;
  localparam int DEFAULT_ALMOST_FULL  = 6;
  localparam int DEFAULT_ALMOST_EMPTY = 2;

  // Pointer width for a given depth; DEPTH must be a power of two >= 2.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int PTR_W = ptr_w(DEFAULT_DEPTH);

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } lane_flags_t;

endpackage

// File: rtl/fifo_lane.sv
// One circular FIFO lane with registered read data and occupancy flags.
// Optional feature macro: FIFO_BANK_ERROR_EN adds a sticky error output.
module fifo_lane
  import fifo_bank_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int ALMOST_FULL  = DEFAULT_ALMOST_FULL,
  parameter int ALMOST_EMPTY = DEFAULT_ALMOST_EMPTY
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output lane_flags_t       flags
`ifdef FIFO_BANK_ERROR_EN
  ,
  output logic              error
`endif
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              pop_ok, push_ok;

  // A full lane still takes a push when a pop frees a slot on the same edge.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = valid_in && ((count_q != CW'(DEPTH)) || pop_ok);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_out_d = pop_ok;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      data_out_d = mem_q[rd_ptr_q];
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // NOTE: storage has no reset; pointers and count alone define which words are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out           = data_out_q;
  assign valid_out          = valid_out_q;
  assign flags.full         = (count_q == CW'(DEPTH));
  assign flags.empty        = (count_q == '0);
  assign flags.almost_full  = (count_q >= CW'(ALMOST_FULL));
  assign flags.almost_empty = (count_q <= CW'(ALMOST_EMPTY));

`ifdef FIFO_BANK_ERROR_EN
  logic error_q, error_d;

  // Sticky: a dropped push or an ignored pop latches until reset.
  always_comb begin
    error_d = error_q | (valid_in & ~push_ok) | (pop & ~pop_ok);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) error_q <= 1'b0;
    else          error_q <= error_d;
  end

  assign error = error_q;
`endif

endmodule

// File: rtl/fifo_bank.sv
// Four independent FIFO lanes plus a pause backpressure OR of almost_full.
// Optional feature macro: FIFO_BANK_ERROR_EN adds sticky error0..3 outputs.
module fifo_bank
  import fifo_bank_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int ALMOST_FULL  = DEFAULT_ALMOST_FULL,
  parameter int ALMOST_EMPTY = DEFAULT_ALMOST_EMPTY
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] dataIn0,
  input  logic [DATA_W-1:0] dataIn1,
  input  logic [DATA_W-1:0] dataIn2,
  input  logic [DATA_W-1:0] dataIn3,
  input  logic              validIn0,
  input  logic              validIn1,
  input  logic              validIn2,
  input  logic              validIn3,
  input  logic              pop0,
  input  logic              pop1,
  input  logic              pop2,
  input  logic              pop3,
  output logic [DATA_W-1:0] dataOut0,
  output logic [DATA_W-1:0] dataOut1,
  output logic [DATA_W-1:0] dataOut2,
  output logic [DATA_W-1:0] dataOut3,
  output logic              validOut0,
  output logic              validOut1,
  output logic              validOut2,
  output logic              validOut3,
  output logic              full0,
  output logic              full1,
  output logic              full2,
  output logic              full3,
  output logic              empty0,
  output logic              empty1,
  output logic              empty2,
  output logic              empty3,
  output logic              almost_full0,
  output logic              almost_full1,
  output logic              almost_full2,
  output logic              almost_full3,
  output logic              almost_empty0,
  output logic              almost_empty1,
  output logic              almost_empty2,
  output logic              almost_empty3,
`ifdef FIFO_BANK_ERROR_EN
  output logic              error0,
  output logic              error1,
  output logic              error2,
  output logic              error3,
`endif
  output logic              pause
);

  logic [DATA_W-1:0] din  [4];
  logic [DATA_W-1:0] dout [4];
  logic [3:0]        vin, popv, vout;
  lane_flags_t       flg  [4];
  logic [3:0]        full_v, empty_v, af_v, ae_v;

  assign din  = '{dataIn0, dataIn1, dataIn2, dataIn3};
  assign vin  = {validIn3, validIn2, validIn1, validIn0};
  assign popv = {pop3, pop2, pop1, pop0};

`ifdef FIFO_BANK_ERROR_EN
  logic [3:0] err_v;
  assign {error3, error2, error1, error0} = err_v;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_lane
    fifo_lane #(
      .DATA_W      (DATA_W),
      .DEPTH       (DEPTH),
      .ALMOST_FULL (ALMOST_FULL),
      .ALMOST_EMPTY(ALMOST_EMPTY)
    ) u_lane (
      .clk      (clk),
      .reset_L  (reset_L),
      .data_in  (din[i]),
      .valid_in (vin[i]),
      .pop      (popv[i]),
      .data_out (dout[i]),
      .valid_out(vout[i]),
`ifdef FIFO_BANK_ERROR_EN
      .error    (err_v[i]),
`endif
      .flags    (flg[i])
    );
    assign full_v[i]  = flg[i].full;
    assign empty_v[i] = flg[i].empty;
    assign af_v[i]    = flg[i].almost_full;
    assign ae_v[i]    = flg[i].almost_empty;
  end

  assign {dataOut3, dataOut2, dataOut1, dataOut0}                 = {dout[3], dout[2], dout[1], dout[0]};
  assign {validOut3, validOut2, validOut1, validOut0}             = vout;
  assign {full3, full2, full1, full0}                             = full_v;
  assign {empty3, empty2, empty1, empty0}                         = empty_v;
  assign {almost_full3, almost_full2, almost_full1, almost_full0} = af_v;
  assign {almost_empty3, almost_empty2, almost_empty1, almost_empty0} = ae_v;
  assign pause = |af_v;

endmodule

// File: tb/tb_fifo_bank.sv
// Directed self-checking bench for fifo_bank (default 8-bit, depth-8 lanes).
// Define FIFO_BANK_ERROR_EN on both RTL and bench to cover the error flags.
module tb_fifo_bank;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [7:0] dataIn0, dataIn1, dataIn2, dataIn3;
  logic       validIn0, validIn1, validIn2, validIn3;
  logic       pop0, pop1, pop2, pop3;
  logic [7:0] dataOut0, dataOut1, dataOut2, dataOut3;
  logic       validOut0, validOut1, validOut2, validOut3;
  logic       full0, full1, full2, full3;
  logic       empty0, empty1, empty2, empty3;
  logic       almost_full0, almost_full1, almost_full2, almost_full3;
  logic       almost_empty0, almost_empty1, almost_empty2, almost_empty3;
  logic       pause;
`ifdef FIFO_BANK_ERROR_EN
  logic       error0, error1, error2, error3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_bank dut (
    .clk(clk), .reset_L(reset_L),
    .dataIn0(dataIn0), .dataIn1(dataIn1), .dataIn2(dataIn2), .dataIn3(dataIn3),
    .validIn0(validIn0), .validIn1(validIn1), .validIn2(validIn2), .validIn3(validIn3),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .dataOut0(dataOut0), .dataOut1(dataOut1), .dataOut2(dataOut2), .dataOut3(dataOut3),
    .validOut0(validOut0), .validOut1(validOut1), .validOut2(validOut2), .validOut3(validOut3),
    .full0(full0), .full1(full1), .full2(full2), .full3(full3),
    .empty0(empty0), .empty1(empty1), .empty2(empty2), .empty3(empty3),
    .almost_full0(almost_full0), .almost_full1(almost_full1),
    .almost_full2(almost_full2), .almost_full3(almost_full3),
    .almost_empty0(almost_empty0), .almost_empty1(almost_empty1),
    .almost_empty2(almost_empty2), .almost_empty3(almost_empty3),
`ifdef FIFO_BANK_ERROR_EN
    .error0(error0), .error1(error1), .error2(error2), .error3(error3),
`endif
    .pause(pause)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0;
    {dataIn0, dataIn1, dataIn2, dataIn3} = '0;
    {validIn0, validIn1, validIn2, validIn3} = '0;
    {pop0, pop1, pop2, pop3} = '0;
    #12;

    // Reset state
    check("rst_empty",    {empty3, empty2, empty1, empty0}, 4'hF);
    check("rst_aempty",   {almost_empty3, almost_empty2, almost_empty1, almost_empty0}, 4'hF);
    check("rst_full",     {full3, full2, full1, full0}, 4'h0);
    check("rst_afull",    {almost_full3, almost_full2, almost_full1, almost_full0}, 4'h0);
    check("rst_pause",    pause, 1'b0);
    check("rst_valid",    {validOut3, validOut2, validOut1, validOut0}, 4'h0);
    check("rst_data",     {dataOut3, dataOut2, dataOut1, dataOut0}, 32'h0);
`ifdef FIFO_BANK_ERROR_EN
    check("rst_error",    {error3, error2, error1, error0}, 4'h0);
`endif
    @(negedge clk);
    reset_L = 1'b1;

    // Lane 0: push A1..A3, pop three, each word one edge after its pop
    @(posedge clk); #1;
    validIn0 = 1'b1;
    dataIn0 = 8'hA1; tick();
    dataIn0 = 8'hA2; tick();
    dataIn0 = 8'hA3; tick();
    validIn0 = 1'b0;
    check("l0_notempty", empty0, 1'b0);
    check("l0_aempty_3", almost_empty0, 1'b0);
    check("l0_valid_pre", validOut0, 1'b0);
    pop0 = 1'b1;
    tick(); check("l0_pop1_d", dataOut0, 8'hA1); check("l0_pop1_v", validOut0, 1'b1);
    tick(); check("l0_pop2_d", dataOut0, 8'hA2); check("l0_pop2_v", validOut0, 1'b1);
    tick(); check("l0_pop3_d", dataOut0, 8'hA3); check("l0_pop3_v", validOut0, 1'b1);
    pop0 = 1'b0;
    check("l0_empty", empty0, 1'b1);
    tick();
    check("l0_idle_v", validOut0, 1'b0);
    check("l0_hold_d", dataOut0, 8'hA3);

    // Lane 2: fill to full, check threshold flags, drop a 9th push
    validIn2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dataIn2 = 8'h20 + 8'(i);
      tick();
      check($sformatf("l2_af_%0d", i + 1),    almost_full2,  1'((i + 1) >= 6));
      check($sformatf("l2_pause_%0d", i + 1), pause,         1'((i + 1) >= 6));
      check($sformatf("l2_full_%0d", i + 1),  full2,         1'((i + 1) == 8));
      check($sformatf("l2_ae_%0d", i + 1),    almost_empty2, 1'((i + 1) <= 2));
    end
    dataIn2 = 8'hFF;
    tick();
    validIn2 = 1'b0;
    check("l2_drop_full", full2, 1'b1);
`ifdef FIFO_BANK_ERROR_EN
    check("l2_drop_err", error2, 1'b1);
`endif
    pop2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("l2_rd_%0d", i), dataOut2, 8'h20 + 8'(i));
      check($sformatf("l2_rv_%0d", i), validOut2, 1'b1);
    end
    tick();
    pop2 = 1'b0;
    check("l2_empty_pop_v", validOut2, 1'b0);
    check("l2_empty", empty2, 1'b1);
    check("l2_pause_off", pause, 1'b0);

    // Lane 1: full, simultaneous push 0x55 and pop
    validIn1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dataIn1 = 8'h10 + 8'(i);
      tick();
    end
    check("l1_full", full1, 1'b1);
    dataIn1 = 8'h55;
    pop1 = 1'b1;
    tick();
    validIn1 = 1'b0;
    check("l1_pp_d", dataOut1, 8'h10);
    check("l1_pp_full", full1, 1'b1);
`ifdef FIFO_BANK_ERROR_EN
    check("l1_pp_noerr", error1, 1'b0);
`endif
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("l1_rd_%0d", i), dataOut1, 8'h10 + 8'(i));
    end
    tick();
    pop1 = 1'b0;
    check("l1_rd_55", dataOut1, 8'h55);
    check("l1_empty", empty1, 1'b1);

    // Lane 3: empty, push 0x33 with pop -> no bypass, count 1
    dataIn3 = 8'h33;
    validIn3 = 1'b1;
    pop3 = 1'b1;
    tick();
    validIn3 = 1'b0;
    pop3 = 1'b0;
    check("l3_nobypass_v", validOut3, 1'b0);
    check("l3_nobypass_d", dataOut3, 8'h00);
    check("l3_count1", {full3, empty3, almost_empty3}, 3'b001);
    pop3 = 1'b1;
    tick();
    pop3 = 1'b0;
    check("l3_rd_d", dataOut3, 8'h33);
    check("l3_rd_v", validOut3, 1'b1);
    check("l3_empty", empty3, 1'b1);

    // Lane 0: five words, one popped, then asynchronous reset between edges
    validIn0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dataIn0 = 8'h50 + 8'(i);
      tick();
    end
    validIn0 = 1'b0;
    pop0 = 1'b1;
    tick();
    pop0 = 1'b0;
    check("l0_pre_rst_d", dataOut0, 8'h50);
    check("l0_pre_rst_v", validOut0, 1'b1);
    #2;
    reset_L = 1'b0;
    #1;
    check("arst_v", validOut0, 1'b0);
    check("arst_d", dataOut0, 8'h00);
    check("arst_empty", empty0, 1'b1);
    check("arst_aempty", almost_empty0, 1'b1);
`ifdef FIFO_BANK_ERROR_EN
    check("arst_err", {error3, error2, error1, error0}, 4'h0);
`endif
    #1;
    reset_L = 1'b1;
    tick();
    check("post_rst_empty", empty0, 1'b1);
    check("post_rst_v", validOut0, 1'b0);
    dataIn0 = 8'h77;
    validIn0 = 1'b1;
    tick();
    validIn0 = 1'b0;
    pop0 = 1'b1;
    tick();
    pop0 = 1'b0;
    check("post_rst_rd", dataOut0, 8'h77);
    check("post_rst_rv", validOut0, 1'b1);

`ifdef FIFO_BANK_ERROR_EN
    // Lane 2: pop on empty sets a sticky error
    check("err2_clear", error2, 1'b0);
    pop2 = 1'b1;
    tick();
    pop2 = 1'b0;
    check("err2_set", error2, 1'b1);
    tick(); tick();
    check("err2_sticky", error2, 1'b1);
    check("err_others", {error3, error1, error0}, 3'b000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_bank.md
FIFO_BANK -- requirements
Module: fifo_bank

Interface
REQ-001 Parameter DATA_W, default 8, lane data width in bits.
REQ-002 Parameter DEPTH, default 8, entries per lane FIFO; power of two.
REQ-003 Parameter ALMOST_FULL, default 6, occupancy at or above which almost_fullN asserts.
REQ-004 Parameter ALMOST_EMPTY, default 2, occupancy at or below which almost_emptyN asserts.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset_L  input  1  asynchronous, active-low reset.
REQ-007 dataInN (N=0..3)  input  DATA_W  lane N write data, driven by the recirculator forward outputs dataOut4..7.
REQ-008 validInN (N=0..3)  input  1  lane N push request, driven by recirculator validOut4..7.
REQ-009 popN (N=0..3)  input  1  lane N read request from the downstream consumer.
REQ-010 dataOutN (N=0..3)  output  DATA_W  lane N registered read data.
REQ-011 validOutN (N=0..3)  output  1  dataOutN holds a valid popped word this cycle.
REQ-012 fullN / emptyN (N=0..3)  output  1  lane N occupancy equals DEPTH / equals 0.
REQ-013 almost_fullN / almost_emptyN (N=0..3)  output  1  lane N threshold flags.
REQ-014 pause  output  1  OR of almost_full0..3; backpressure toward the recirculator and upstream stage.

Function
REQ-015 Each lane SHALL be an independent circular FIFO with a write pointer, a read pointer (log2(DEPTH) bits, natural wrap DEPTH-1 -> 0) and an occupancy counter (log2(DEPTH)+1 bits, range 0..DEPTH).
REQ-016 A push SHALL be accepted when validInN=1 and (count<DEPTH or an accepted pop occurs in the same cycle); the word is written at wr_ptr and wr_ptr increments.
REQ-017 A pop SHALL be accepted when popN=1 and count>0; dataOutN <= mem[rd_ptr], validOutN <= 1 on that edge (latency 1 cycle), and rd_ptr increments.
REQ-018 When no pop is accepted, validOutN SHALL go to 0 on the next edge and dataOutN SHALL hold its last value.
REQ-019 A pop on an empty lane SHALL be ignored, including when a push occurs in the same cycle; the pushed word is not bypassed to the output.
REQ-020 A push on a full lane without a simultaneous pop SHALL be dropped, leaving memory, pointers and count unchanged.
REQ-021 Count SHALL update as +1 for a push only, -1 for a pop only, and unchanged for both or neither.
REQ-022 full, empty, almost_full (count>=ALMOST_FULL), almost_empty (count<=ALMOST_EMPTY) and pause SHALL be combinational decodes of the registered counts.

Reset
REQ-023 While reset_L=0, all pointers, counts, dataOutN (0x00) and validOutN (0) SHALL clear immediately, regardless of clk.
REQ-024 After reset, emptyN=1, almost_emptyN=1, fullN=0, almost_fullN=0 and pause=0; memory contents are don't-care.
REQ-025 Reset asserted mid-operation SHALL discard all stored words; the first edge after release with reset_L=1 operates normally.

Configuration
REQ-026 With macro FIFO_BANK_ERROR_EN defined, the block SHALL add an output errorN (N=0..3, 1 bit) that is sticky: set on a dropped push (REQ-020) or an ignored pop (REQ-019), cleared only by reset.
REQ-027 Without FIFO_BANK_ERROR_EN, errorN ports and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package fifo_bank_pkg SHALL hold DATA_W, DEPTH, ALMOST_FULL and ALMOST_EMPTY defaults, plus the derived pointer width PTR_W=log2(DEPTH).
REQ-029 Sub-module fifo_lane (one FIFO with flags) SHALL be instantiated four times; fifo_bank adds only instance wiring and the pause OR.

Verification
REQ-030 Reset, push 0xA1,0xA2,0xA3 on lane 0, then pop 3 cycles -> dataOut0 = 0xA1,0xA2,0xA3 on consecutive cycles, each one edge after its pop; validOut0=1 for those 3 cycles; then empty0=1.
REQ-031 Push 8 words on lane 2 -> almost_full2 and pause assert when count reaches 6; full2 asserts at 8; a 9th push is dropped and count stays at 8.
REQ-032 Lane 1 full, push 0x55 together with a pop -> count stays at 8 and 0x55 is read out after the 7 older words.
REQ-033 Lane 3 empty, push 0x33 together with a pop -> validOut3=0 and count=1; the next pop returns 0x33.
REQ-034 Fill lane 0 with 5 words, assert reset_L=0 between clock edges -> counts clear and validOut0=0 immediately; after release, empty0=1.
REQ-035 FIFO_BANK_ERROR_EN defined, pop on empty lane 2 -> error2=1 from the next edge and it stays 1 until reset.
